// File: rtl/array_flush_walker.sv
// ---------------------------------------------------------------------------
// array_flush_walker
//
// Purpose:
//   Initiator-side sequencer for a per-set state array (tag/valid/dirty).
//   On start it walks every set index in ascending order and reads each
//   entry. Any non-zero entry is offered to the memory/writeback side over a
//   valid/ready handshake. When the flush variant is built, the entry is
//   then cleared. Used for cache flush, invalidate-all and debug dump.
//
// Build option:
//   ARRAY_FLUSH_CLEAR_EN  defined   -> entries are zeroed after their
//                                      writeback (flush / invalidate-all).
//                         undefined -> no CLEAR state, arr_load tied low,
//                                      the array is left untouched (dump).
//
// Parameters:
//   s_index   index width (arr_index, wb_index)
//   width     entry width of the walked array
//   num_sets  number of sets walked, 1..2**s_index
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a walk; only looked at while idle
//   busy         high in every state except idle
//   done         one-cycle pulse at the end of a walk
//   arr_read     array read strobe; arr_dataout is valid the next cycle
//   arr_load     array write strobe
//   arr_index    set index presented to the array (0 while idle)
//   arr_datain   array write data; always zero
//   arr_dataout  registered array read data
//   wb_valid     writeback request valid
//   wb_ready     writeback sink ready
//   wb_index     set index of the pending writeback
//   wb_data      entry contents of the pending writeback
//   wb_count     writebacks completed in the current / last walk
// ---------------------------------------------------------------------------
module array_flush_walker #(
  parameter int s_index  = 3,
  parameter int width    = 1,
  parameter int num_sets = 2**s_index
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               arr_read,
  output logic               arr_load,
  output logic [s_index-1:0] arr_index,
  output logic [width-1:0]   arr_datain,
  input  logic [width-1:0]   arr_dataout,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [s_index-1:0] wb_index,
  output logic [width-1:0]   wb_data,
  output logic [s_index:0]   wb_count
);

  // Highest set index visited; the walk stops here instead of wrapping.
  localparam logic [s_index-1:0] last_idx = s_index'(num_sets - 1);

`ifdef ARRAY_FLUSH_CLEAR_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WB    = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd5
  } state_t;
`endif

  state_t             state;
  logic [s_index-1:0] idx;
  logic               at_last;

`ifdef ARRAY_FLUSH_CLEAR_EN
  logic               arr_load_q;
  assign arr_load = arr_load_q;
`else
  assign arr_load = 1'b0;
`endif

  // Entries are only ever cleared, never rewritten with other data.
  assign arr_datain = '0;

  assign at_last = (idx == last_idx);

  // Single state machine. Every output is a register whose value is set on
  // the transition into the state that owns it, so nothing reaches an output
  // combinationally from an input (in particular wb_ready -> wb_valid).
  // "Advance" below means: stop in DONE at the last set, otherwise step idx
  // and issue the next read straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      arr_read   <= 1'b0;
`ifdef ARRAY_FLUSH_CLEAR_EN
      arr_load_q <= 1'b0;
`endif
      arr_index  <= '0;
      wb_valid   <= 1'b0;
      wb_index   <= '0;
      wb_data    <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            wb_count  <= '0;
            busy      <= 1'b1;
            arr_read  <= 1'b1;
            arr_index <= '0;
          end
        end

        READ: begin
          // The array samples the strobe at this edge; data shows up in CHECK.
          arr_read <= 1'b0;
          state    <= CHECK;
        end

        CHECK: begin
          if (arr_dataout != '0) begin
            wb_data  <= arr_dataout;
            wb_index <= idx;
            wb_valid <= 1'b1;
            state    <= WB;
          end else if (at_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx       <= idx + 1'b1;
            arr_index <= idx + 1'b1;
            arr_read  <= 1'b1;
            state     <= READ;
          end
        end

        WB: begin
          // wb_index/wb_data are untouched here, so they stay stable while
          // the sink stalls.
          if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
            wb_count <= wb_count + 1'b1;
`ifdef ARRAY_FLUSH_CLEAR_EN
            arr_load_q <= 1'b1;
            state      <= CLEAR;
`else
            if (at_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx       <= idx + 1'b1;
              arr_index <= idx + 1'b1;
              arr_read  <= 1'b1;
              state     <= READ;
            end
`endif
          end
        end

`ifdef ARRAY_FLUSH_CLEAR_EN
        CLEAR: begin
          // Zero is written at this edge (arr_index still equals idx).
          arr_load_q <= 1'b0;
          if (at_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx       <= idx + 1'b1;
            arr_index <= idx + 1'b1;
            arr_read  <= 1'b1;
            state     <= READ;
          end
        end
`endif

        DONE: begin
          // start is deliberately ignored here; a new walk starts from IDLE.
          done      <= 1'b0;
          busy      <= 1'b0;
          arr_index <= '0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          arr_read  <= 1'b0;
          arr_index <= '0;
          wb_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Array port protocol: never read and write in the same cycle.
  a_no_read_and_load : assert property (
    @(posedge clk) disable iff (!rst_n) !(arr_read && arr_load)
  );

  // A stalled writeback keeps its request and payload unchanged.
  a_wb_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (wb_valid && !wb_ready) |=> (wb_valid && $stable(wb_index) && $stable(wb_data))
  );

endmodule

// File: tb/tb_array_flush_walker.sv
// ---------------------------------------------------------------------------
// tb_array_flush_walker
//
// Directed self-checking bench for array_flush_walker (s_index=3, width=1,
// num_sets=8). A small behavioural array answers reads one cycle later and
// applies writes; a negedge monitor logs reads, loads, handshakes and the
// done pulse. Expected values follow ARRAY_FLUSH_CLEAR_EN.
// ---------------------------------------------------------------------------
module tb_array_flush_walker;

  localparam int S = 3;
  localparam int W = 1;
  localparam int N = 8;

`ifdef ARRAY_FLUSH_CLEAR_EN
  localparam int PER_WB   = 2;
  localparam bit CLEAR_ON = 1'b1;
`else
  localparam int PER_WB   = 1;
  localparam bit CLEAR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic         arr_read;
  logic         arr_load;
  logic [S-1:0] arr_index;
  logic [W-1:0] arr_datain;
  logic [W-1:0] arr_dataout = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b1;
  logic [S-1:0] wb_index;
  logic [W-1:0] wb_data;
  logic [S:0]   wb_count;

  int nchecks = 0;
  int nerrors = 0;

  array_flush_walker #(.s_index(S), .width(W), .num_sets(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .arr_read   (arr_read),
    .arr_load   (arr_load),
    .arr_index  (arr_index),
    .arr_datain (arr_datain),
    .arr_dataout(arr_dataout),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_index   (wb_index),
    .wb_data    (wb_data),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  // Behavioural array: registered read data, write on arr_load.
  logic [N-1:0] mem = '0;
  logic         preload = 1'b0;
  logic [N-1:0] preload_val = '0;

  always @(posedge clk) begin
    if (preload) mem <= preload_val;
    else if (arr_load) mem[arr_index] <= arr_datain[0];
    if (arr_read) arr_dataout <= mem[arr_index];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int           rd_q[$];
  int           hs_idx_q[$];
  int           hs_data_q[$];
  logic [N-1:0] ld_mask;
  int           wbv_cycles;
  int           done_cycles;
  int           done_at;
  int           busy_first;
  bit           seen_busy;
  int           unstable;
  logic [S-1:0] hold_idx;
  logic [W-1:0] hold_data;
  bit           prev_stall;

  always @(negedge clk) begin
    if (arr_read) rd_q.push_back(int'(arr_index));
    if (arr_load) ld_mask[arr_index] = 1'b1;
    if (wb_valid) begin
      wbv_cycles++;
      if (prev_stall && (wb_index !== hold_idx || wb_data !== hold_data)) unstable++;
      hold_idx  = wb_index;
      hold_data = wb_data;
      if (wb_ready) begin
        hs_idx_q.push_back(int'(wb_index));
        hs_data_q.push_back(int'(wb_data));
      end
    end
    prev_stall = wb_valid && !wb_ready;
    if (done) begin
      done_cycles++;
      done_at = cyc;
    end
    if (busy && !seen_busy) begin
      seen_busy  = 1'b1;
      busy_first = cyc;
    end
  end

  task automatic clear_mon();
    rd_q.delete();
    hs_idx_q.delete();
    hs_data_q.delete();
    ld_mask     = '0;
    wbv_cycles  = 0;
    done_cycles = 0;
    done_at     = 0;
    busy_first  = 0;
    seen_busy   = 1'b0;
    unstable    = 0;
    prev_stall  = 1'b0;
  endtask

  task automatic preload_mem(input logic [N-1:0] v);
    @(posedge clk) #1;
    preload     = 1'b1;
    preload_val = v;
    @(posedge clk) #1;
    preload     = 1'b0;
  endtask

  // Called at posedge+1; the next edge is the one that samples start.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse, then one more cycle so the DUT is idle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk) #1;
      n++;
    end
    nchecks++;
    if (done !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
    @(posedge clk) #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (wb_valid !== 1'b1 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    nchecks++;
    if (wb_valid !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL %s_valid_timeout: wb_valid=%b, required 1", name, wb_valid);
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    start    = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {busy, done, arr_read, arr_load, arr_index, arr_datain,
            wb_valid, wb_index, wb_data, wb_count, 7'd0};
    nchecks++;
    if (outs !== 24'd0) begin
      nerrors++;
      $display("[TB] FAIL reset_outputs: got %h, required 000000", outs);
    end
    start = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
    nchecks++;
    if (busy !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_all_zero();
    int bad;
    preload_mem(8'h00);
    clear_mon();
    pulse_start();
    wait_done("all_zero");
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (i >= rd_q.size() || rd_q[i] != i) bad++;
    end
    nchecks++;
    if (rd_q.size() != N || bad != 0) begin
      nerrors++;
      $display("[TB] FAIL zero_reads: got %0d reads (%0d out of order), required 8 in order 0..7", rd_q.size(), bad);
    end
    nchecks++;
    if (wbv_cycles != 0) begin
      nerrors++;
      $display("[TB] FAIL zero_wb_valid: got %0d valid cycles, required 0", wbv_cycles);
    end
    nchecks++;
    if (done_at - busy_first != 2 * N) begin
      nerrors++;
      $display("[TB] FAIL zero_latency: got %0d, required %0d", done_at - busy_first, 2 * N);
    end
    nchecks++;
    if (done_cycles != 1) begin
      nerrors++;
      $display("[TB] FAIL zero_done_width: got %0d cycles, required 1", done_cycles);
    end
    nchecks++;
    if (wb_count !== 4'd0 || busy !== 1'b0 || arr_index !== 3'd0) begin
      nerrors++;
      $display("[TB] FAIL zero_end_state: wb_count=%0d busy=%b arr_index=%0d, required 0 0 0", wb_count, busy, arr_index);
    end
  endtask

  task automatic test_two_entries(input string name, input logic [N-1:0] init,
                                  input int ia, input int ib);
    logic [N-1:0] exp_mask;
    logic [N-1:0] exp_mem;
    exp_mask = CLEAR_ON ? init : '0;
    exp_mem  = CLEAR_ON ? '0 : init;
    wb_ready = 1'b1;
    preload_mem(init);
    clear_mon();
    pulse_start();
    wait_done(name);
    nchecks++;
    if (hs_idx_q.size() != 2 ||
        (hs_idx_q.size() > 1 && (hs_idx_q[0] != ia || hs_idx_q[1] != ib))) begin
      nerrors++;
      $display("[TB] FAIL %s_wb_index: got %0d handshakes first=%0d second=%0d, required %0d then %0d",
               name, hs_idx_q.size(), hs_idx_q.size() > 0 ? hs_idx_q[0] : -1,
               hs_idx_q.size() > 1 ? hs_idx_q[1] : -1, ia, ib);
    end
    nchecks++;
    if (hs_data_q.size() != 2 ||
        (hs_data_q.size() > 1 && (hs_data_q[0] != 1 || hs_data_q[1] != 1))) begin
      nerrors++;
      $display("[TB] FAIL %s_wb_data: got %0d entries, required two of value 1", name, hs_data_q.size());
    end
    nchecks++;
    if (ld_mask !== exp_mask) begin
      nerrors++;
      $display("[TB] FAIL %s_load_mask: got %b, required %b", name, ld_mask, exp_mask);
    end
    nchecks++;
    if (wb_count !== 4'd2) begin
      nerrors++;
      $display("[TB] FAIL %s_wb_count: got %0d, required 2", name, wb_count);
    end
    nchecks++;
    if (done_at - busy_first != 2 * N + 2 * PER_WB) begin
      nerrors++;
      $display("[TB] FAIL %s_latency: got %0d, required %0d", name, done_at - busy_first, 2 * N + 2 * PER_WB);
    end
    nchecks++;
    if (mem !== exp_mem) begin
      nerrors++;
      $display("[TB] FAIL %s_array_after: got %b, required %b", name, mem, exp_mem);
    end
    // Re-walk: a flushed array yields nothing, a dumped one yields the same.
    clear_mon();
    pulse_start();
    wait_done({name, "_rewalk"});
    nchecks++;
    if (wb_count !== (CLEAR_ON ? 4'd0 : 4'd2)) begin
      nerrors++;
      $display("[TB] FAIL %s_rewalk_count: got %0d, required %0d", name, wb_count, CLEAR_ON ? 0 : 2);
    end
  endtask

  task automatic test_stall();
    wb_ready = 1'b0;
    preload_mem(8'b0010_0000);
    clear_mon();
    pulse_start();
    wait_valid("stall");
    repeat (4) @(posedge clk);
    #1 wb_ready = 1'b1;
    wait_done("stall");
    nchecks++;
    if (wbv_cycles != 5 || unstable != 0) begin
      nerrors++;
      $display("[TB] FAIL stall_hold: valid %0d cycles, %0d changes, required 5 cycles 0 changes", wbv_cycles, unstable);
    end
    nchecks++;
    if (hs_idx_q.size() != 1 || (hs_idx_q.size() > 0 && hs_idx_q[0] != 5)) begin
      nerrors++;
      $display("[TB] FAIL stall_handshake: got %0d handshakes, first index %0d, required 1 at index 5",
               hs_idx_q.size(), hs_idx_q.size() > 0 ? hs_idx_q[0] : -1);
    end
    nchecks++;
    if (wb_count !== 4'd1) begin
      nerrors++;
      $display("[TB] FAIL stall_wb_count: got %0d, required 1", wb_count);
    end
    nchecks++;
    if (done_at - busy_first != 2 * N + PER_WB + 4) begin
      nerrors++;
      $display("[TB] FAIL stall_latency: got %0d, required %0d", done_at - busy_first, 2 * N + PER_WB + 4);
    end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    preload_mem(8'h00);
    clear_mon();
    start = 1'b1;
    @(posedge clk) #1;
    wait_done("b2b_first");
    nchecks++;
    if (busy !== 1'b0 || rd_q.size() != N || done_cycles != 1) begin
      nerrors++;
      $display("[TB] FAIL b2b_gap: busy=%b reads=%0d dones=%0d, required 0 8 1", busy, rd_q.size(), done_cycles);
    end
    @(posedge clk) #1;
    nchecks++;
    if (busy !== 1'b1 || arr_read !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL b2b_restart: busy=%b arr_read=%b, required 1 1", busy, arr_read);
    end
    start = 1'b0;
    wait_done("b2b_second");
    @(posedge clk) #1;
    nchecks++;
    if (busy !== 1'b0 || done_cycles != 2) begin
      nerrors++;
      $display("[TB] FAIL b2b_stop: busy=%b dones=%0d, required 0 2", busy, done_cycles);
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [23:0] outs;
    wb_ready = 1'b0;
    preload_mem(8'b0000_1000);
    clear_mon();
    pulse_start();
    wait_valid("rst_wb");
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, done, arr_read, arr_load, arr_index, arr_datain,
            wb_valid, wb_index, wb_data, wb_count, 7'd0};
    nchecks++;
    if (outs !== 24'd0) begin
      nerrors++;
      $display("[TB] FAIL rst_wb_outputs: got %h, required 000000", outs);
    end
    @(posedge clk) #1;
    @(posedge clk) #1;
    nchecks++;
    if (mem !== 8'b0000_1000) begin
      nerrors++;
      $display("[TB] FAIL rst_wb_not_cleared: array %b, required 00001000", mem);
    end
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    @(posedge clk) #1;
    clear_mon();
    pulse_start();
    wait_done("rst_wb_rewalk");
    nchecks++;
    if (hs_idx_q.size() != 1 || (hs_idx_q.size() > 0 && hs_idx_q[0] != 3) || wb_count !== 4'd1) begin
      nerrors++;
      $display("[TB] FAIL rst_wb_rewalk: %0d handshakes first=%0d wb_count=%0d, required 1 at index 3 count 1",
               hs_idx_q.size(), hs_idx_q.size() > 0 ? hs_idx_q[0] : -1, wb_count);
    end
    nchecks++;
    if (mem !== (CLEAR_ON ? 8'h00 : 8'h08)) begin
      nerrors++;
      $display("[TB] FAIL rst_wb_array_after: got %b, required %b", mem, CLEAR_ON ? 8'h00 : 8'h08);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_all_zero();
    test_two_entries("flush_2_7", 8'b1000_0100, 2, 7);
    test_stall();
    test_back_to_back();
    test_reset_mid_wb();
    test_two_entries("dump_0_1", 8'b0000_0011, 0, 1);
    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
